// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared opcode, state and counter definitions for the MDU controller
package mdu_pkg;

  localparam int CNT_W = 4;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Multi-cycle ops: everything that occupies the unit and later commits HI/LO.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op >= OP_MULT && op <= OP_DIVU) || (op >= OP_MADD && op <= OP_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_result_calc.sv
// rtl/mdu_result_calc.sv - combinational HI/LO result for the latched MDU operation
module mdu_result_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] new_hi_o,
  output logic [31:0] new_lo_o,
  output logic        write_en_o
);

  logic [63:0] acc;
  logic [63:0] sprod;
  logic [63:0] uprod;
  logic        sdiv;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] divisor;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;

  assign acc   = {hi_i, lo_i};
  assign sprod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign uprod = {32'd0, a_i} * {32'd0, b_i};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  assign sdiv    = (op_i == OP_DIV);
  assign abs_a   = (sdiv && a_i[31]) ? -a_i : a_i;
  assign abs_b   = (sdiv && b_i[31]) ? -b_i : b_i;
  assign divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign uq      = abs_a / divisor;
  assign ur      = abs_a % divisor;
  assign sq      = (a_i[31] ^ b_i[31]) ? -uq : uq;
  assign sr      = a_i[31] ? -ur : ur;

  always_comb begin
    {new_hi_o, new_lo_o} = acc;
    write_en_o           = 1'b0;
    case (op_i)
      OP_MULT:  begin {new_hi_o, new_lo_o} = sprod;       write_en_o = 1'b1; end
      OP_MULTU: begin {new_hi_o, new_lo_o} = uprod;       write_en_o = 1'b1; end
      OP_MADD:  begin {new_hi_o, new_lo_o} = acc + sprod; write_en_o = 1'b1; end
      OP_MADDU: begin {new_hi_o, new_lo_o} = acc + uprod; write_en_o = 1'b1; end
      OP_MSUB:  begin {new_hi_o, new_lo_o} = acc - sprod; write_en_o = 1'b1; end
      OP_MSUBU: begin {new_hi_o, new_lo_o} = acc - uprod; write_en_o = 1'b1; end
      OP_DIV: begin
        {new_hi_o, new_lo_o} = {sr, sq};
        write_en_o           = (b_i != 32'd0);
      end
      OP_DIVU: begin
        {new_hi_o, new_lo_o} = {ur, uq};
        write_en_o           = (b_i != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide sequencer owning HI/LO, with stall generation
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cancel_i,
  input  logic        ifmdu_d_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall_o
);

  // Busy spans RUN plus COMMIT, so the counter loads one less than the total.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      acc_hi_q, acc_hi_d;
  logic [31:0]      acc_lo_q, acc_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      new_hi;
  logic [31:0]      new_lo;
  logic             wr_en;

  mdu_result_calc u_calc (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .hi_i       (acc_hi_q),
    .lo_i       (acc_lo_q),
    .new_hi_o   (new_hi),
    .new_lo_o   (new_lo),
    .write_en_o (wr_en)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_o   = (state_q != ST_IDLE);
    done_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !cancel_i) begin
          if (is_long_op(op_i)) begin
            op_d     = op_i;
            a_d      = a_i;
            b_d      = b_i;
            acc_hi_d = hi_q;
            acc_lo_d = lo_q;
            cnt_d    = is_div_op(op_i) ? DIV_LOAD : MUL_LOAD;
            state_d  = (cnt_d == '0) ? ST_COMMIT : ST_RUN;
          end else if (op_i == OP_MTHI) begin
            hi_d = a_i;
          end else if (op_i == OP_MTLO) begin
            lo_d = a_i;
          end
        end
      end
      ST_RUN: begin
        if (cancel_i) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (!cancel_i) begin
          done_o = 1'b1;
          if (wr_en) begin
            hi_d = new_hi;
            lo_d = new_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_NONE;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign stall_o = ifmdu_d_i & (busy_o | (start_i & is_long_op(op_i)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for mdu_ctrl
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [3:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        cancel_i;
  logic        ifmdu_d_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stall_o;

  int checks;
  int errors;
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  logic [63:0] sb_q[$];

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .cancel_i  (cancel_i),
    .ifmdu_d_i (ifmdu_d_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .stall_o   (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] acc, sp, up;
    sa  = $signed(a);
    sb  = $signed(b);
    acc = {hi, lo};
    sp  = sa * sb;
    up  = {32'd0, a} * {32'd0, b};
    case (op)
      OP_MULT:  return sp;
      OP_MULTU: return up;
      OP_MADD:  return acc + sp;
      OP_MADDU: return acc + up;
      OP_MSUB:  return acc - sp;
      OP_MSUBU: return acc - up;
      OP_DIV: begin
        if (b == 32'd0) return acc;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return acc;
        return {a % b, a / b};
      end
      default: return acc;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input string name);
    int busy_cnt;
    int done_cyc;
    logic [63:0] exp;
    sb_q.push_back(model(op, a, b, model_hi, model_lo));
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    step();
    start_i = 1'b0; op_i = OP_NONE;
    busy_cnt = 0;
    done_cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done_o) done_cyc = i;
      if (!busy_o) break;
      busy_cnt++;
      step();
    end
    checks++;
    if (busy_cnt !== n) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, n);
    end
    checks++;
    if (done_cyc !== n) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, n);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({hi_o, lo_o} !== exp) begin
      errors++;
      $display("FAIL %s hilo: got %h_%h expected %h_%h", name, hi_o, lo_o, exp[63:32], exp[31:0]);
    end
    {model_hi, model_lo} = exp;
    step();
  endtask

  task automatic move(input logic [3:0] op, input logic [31:0] a, input logic cancel,
                      input string name);
    start_i = 1'b1; op_i = op; a_i = a; cancel_i = cancel;
    step();
    start_i = 1'b0; op_i = OP_NONE; cancel_i = 1'b0;
    if (!cancel) begin
      if (op == OP_MTHI) model_hi = a;
      if (op == OP_MTLO) model_lo = a;
    end
    @(negedge clk);
    checks++;
    if (hi_o !== model_hi || lo_o !== model_lo || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: got hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0",
               name, hi_o, lo_o, busy_o, model_hi, model_lo);
    end
    step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b done=%b stall=%b expected 0 0 0", busy_o, done_o, stall_o);
    end
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo: got %h_%h expected 0_0", hi_o, lo_o);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_mult();
    run_long(OP_MULT, 32'hFFFF_FFFF, 32'd2, 5, "mult_neg");
    checks++;
    if (model_hi !== 32'hFFFF_FFFF || model_lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mult_ref: got %h_%h expected ffffffff_fffffffe", model_hi, model_lo);
    end
  endtask

  task automatic test_multu_div();
    run_long(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, "multu");
    run_long(OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, "div_neg");
    run_long(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");
    run_long(OP_DIVU, 32'hFFFF_FFF9, 32'd10, 10, "divu");
  endtask

  task automatic test_mthi_maddu();
    move(OP_MTHI, 32'h1234_5678, 1'b0, "mthi");
    move(OP_MTLO, 32'd1, 1'b0, "mtlo");
    run_long(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, "maddu");
    run_long(OP_MADD, 32'hFFFF_FFFD, 32'd7, 5, "madd");
    run_long(OP_MSUBU, 32'h0001_0000, 32'h0002_0000, 5, "msubu");
  endtask

  task automatic test_divu_zero();
    move(OP_MTHI, 32'hAA, 1'b0, "mthi_aa");
    move(OP_MTLO, 32'hBB, 1'b0, "mtlo_bb");
    run_long(OP_DIVU, 32'd5, 32'd0, 10, "divu_zero");
    run_long(OP_DIV, 32'd5, 32'd0, 10, "div_zero");
  endtask

  task automatic test_cancel();
    start_i = 1'b1; op_i = OP_DIV; a_i = 32'd100; b_i = 32'd7;
    step();
    start_i = 1'b0; op_i = OP_NONE;
    step();
    step();
    cancel_i = 1'b1;
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL cancel_cycle: got done=%b busy=%b expected done=0 busy=1", done_o, busy_o);
    end
    step();
    cancel_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL cancel_busy: got %b expected 0", busy_o);
    end
    for (int i = 0; i < 12; i++) step();
    @(negedge clk);
    checks++;
    if (hi_o !== model_hi || lo_o !== model_lo) begin
      errors++;
      $display("FAIL cancel_hilo: got %h_%h expected %h_%h", hi_o, lo_o, model_hi, model_lo);
    end
    step();
    move(OP_MTHI, 32'hDEAD_BEEF, 1'b1, "mthi_cancel");
    move(OP_MULT, 32'd9, 1'b1, "mult_cancel");
    run_long(OP_MULT, 32'd6, 32'hFFFF_FFF9, 5, "mult_after_cancel");
  endtask

  task automatic test_stall_reset();
    int stall_cnt;
    ifmdu_d_i = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle: got %b expected 0", stall_o);
    end
    step();
    sb_q.push_back(model(OP_MULT, 32'd3, 32'd4, model_hi, model_lo));
    start_i = 1'b1; op_i = OP_MULT; a_i = 32'd3; b_i = 32'd4;
    stall_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall_o) stall_cnt++;
      else if (i > 0) break;
      step();
      start_i = 1'b0; op_i = OP_NONE;
    end
    checks++;
    if (stall_cnt !== 6) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected 6", stall_cnt);
    end
    {model_hi, model_lo} = sb_q.pop_front();
    checks++;
    if (hi_o !== model_hi || lo_o !== model_lo) begin
      errors++;
      $display("FAIL stall_mult_hilo: got %h_%h expected %h_%h", hi_o, lo_o, model_hi, model_lo);
    end
    ifmdu_d_i = 1'b0;
    step();
    start_i = 1'b1; op_i = OP_MULT; a_i = 32'd11; b_i = 32'd13;
    step();
    start_i = 1'b0; op_i = OP_NONE;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b hilo=%h_%h expected busy=0 hilo=0_0", busy_o, hi_o, lo_o);
    end
    model_hi = 32'd0;
    model_lo = 32'd0;
    step();
    reset = 1'b1;
    step();
    run_long(OP_MSUB, 32'd3, 32'hFFFF_FFFB, 5, "msub_after_reset");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    model_hi  = 32'd0;
    model_lo  = 32'd0;
    reset     = 1'b0;
    start_i   = 1'b0;
    op_i      = OP_NONE;
    a_i       = 32'd0;
    b_i       = 32'd0;
    cancel_i  = 1'b0;
    ifmdu_d_i = 1'b0;
    step();
    test_reset();
    test_mult();
    test_multu_div();
    test_mthi_maddu();
    test_divu_zero();
    test_cancel();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
